// File: rtl/uart_rx_sampler.sv
// UART receive sampler: start detection, mid-bit sampling at 16x oversampling,
// 8 data bits LSB first, optional parity and one stop bit.
module uart_rx_sampler (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_enable,
    input  logic       tick_baud_x16,
    input  logic       parity_enable,
    input  logic       parity_odd,
    input  logic       rx,
    output logic       tick_baud,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       frame_err,
    output logic       rx_parity_err,
    output logic       idle
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        parity_bit_q, parity_bit_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        parity_err_q, parity_err_d;
    logic        sample;

    // Sample point: mid-bit tick while a frame is in progress.
    always_comb begin
        sample = tick_baud_x16 && (cnt_q == 4'd7) && (state_q != StIdle);
    end

    // Next-state logic: nothing moves without a tick; disable aborts at once.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        parity_bit_d = parity_bit_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;

        if (!rx_enable) begin
            state_d = StIdle;
            cnt_d   = 4'd0;
        end else if (tick_baud_x16) begin
            if (state_q == StIdle) begin
                if (!rx) begin
                    state_d = StStart;
                    cnt_d   = 4'd0;
                end
            end else begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    unique case (state_q)
                        StStart: begin
                            if (rx) begin
                                state_d = StIdle;
                            end else begin
                                state_d   = StData;
                                bit_idx_d = 3'd0;
                            end
                        end
                        StData: begin
                            shift_d   = {rx, shift_q[7:1]};
                            bit_idx_d = bit_idx_q + 3'd1;
                            if (bit_idx_q == 3'd7) begin
                                state_d = parity_enable ? StParity : StStop;
                            end
                        end
                        StParity: begin
                            parity_bit_d = rx;
                            state_d      = StStop;
                        end
                        StStop: begin
                            rx_valid_d   = 1'b1;
                            rx_data_d    = shift_q;
                            frame_err_d  = ~rx;
                            parity_err_d = parity_enable &
                                           ((^shift_q) ^ parity_odd ^ parity_bit_q);
                            state_d      = StIdle;
                        end
                        default: state_d = StIdle;
                    endcase
                end
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            parity_bit_q <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            parity_bit_q <= parity_bit_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    // Output mapping.
    always_comb begin
        tick_baud     = sample;
        rx_valid      = rx_valid_q;
        rx_data       = rx_data_q;
        frame_err     = frame_err_q;
        rx_parity_err = parity_err_q;
        idle          = (state_q == StIdle);
    end

endmodule
